// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port integer register file.
//   XLEN_DEFAULT / NREG_DEFAULT / NRP_DEFAULT : default data width, register
//                                               count and read-port count
//   NRP_MAX                                   : largest supported read-port count
//   addr_width()                              : register address width for NREG
//   rd_addr_lo() / rd_data_lo()               : low bit of port k's slice in the
//                                               flattened read address/data buses
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;
    localparam int NRP_DEFAULT  = 2;
    localparam int NRP_MAX      = 4;

    // Ceiling log2 of the register count, never less than one bit.
    function automatic int addr_width(input int nreg);
        int w;
        w = 1;
        while ((1 << w) < nreg) begin
            w++;
        end
        return w;
    endfunction

    // Low bit of read port k inside r_addr.
    function automatic int rd_addr_lo(input int k, input int aw);
        return k * aw;
    endfunction

    // Low bit of read port k inside r_data.
    function automatic int rd_data_lo(input int k, input int xlen);
        return k * xlen;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits used by the issue stage to detect RAW hazards.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset, clears every busy bit
//   set_ena    : mark set_addr busy (a producer was issued)
//   set_addr   : register to mark busy
//   clr0_ena   : clear busy bit of clr0_addr (write port 0 retiring)
//   clr0_addr  : register written by port 0
//   clr1_ena   : clear busy bit of clr1_addr (write port 1 retiring)
//   clr1_addr  : register written by port 1
//   flush      : clear every busy bit, beats set and clear
//   busy       : registered busy vector, one bit per register
// -----------------------------------------------------------------------------
module regfile_scoreboard
#(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_ena,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr0_ena,
    input  logic [AW-1:0]   clr0_addr,
    input  logic            clr1_ena,
    input  logic [AW-1:0]   clr1_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // Clears are applied before the set so a register that retires and is
    // re-issued in the same cycle stays busy for its new producer. A flush
    // discards everything in flight, so it is applied last.
    always_comb begin
        busy_next = busy;
        if (clr0_ena) begin
            busy_next[clr0_addr] = 1'b0;
        end
        if (clr1_ena) begin
            busy_next[clr1_addr] = 1'b0;
        end
        if (set_ena) begin
            busy_next[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        // The hard-wired zero register never has a pending producer.
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with two write ports, NRP combinational
// read ports, optional write-to-read bypass and a busy scoreboard.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   w0_ena/addr/data : write port 0 (ALU writeback)
//   w1_ena/addr/data : write port 1 (load/MUL writeback), wins on collision
//   r_addr       : read addresses, port k at [k*AW +: AW]
//   r_data       : read data, port k at [k*XLEN +: XLEN]
//   r_busy       : registered busy bit of each read address
//   sb_set_ena   : mark sb_set_addr pending
//   sb_set_addr  : register to mark pending
//   sb_flush     : clear every busy bit
//   busy_vec     : full scoreboard state
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREG     = NREG_DEFAULT,
    parameter int AW       = addr_width(NREG),
    parameter int NRP      = NRP_DEFAULT,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              w0_ena,
    input  logic [AW-1:0]     w0_addr,
    input  logic [XLEN-1:0]   w0_data,
    input  logic              w1_ena,
    input  logic [AW-1:0]     w1_addr,
    input  logic [XLEN-1:0]   w1_data,
    input  logic [NRP*AW-1:0] r_addr,
    output logic [NRP*XLEN-1:0] r_data,
    output logic [NRP-1:0]    r_busy,
    input  logic              sb_set_ena,
    input  logic [AW-1:0]     sb_set_addr,
    input  logic              sb_flush,
    output logic [NREG-1:0]   busy_vec
);

    logic [XLEN-1:0] regs [NREG];

    logic w0_commit;
    logic w1_commit;

    // Writes to the hard-wired zero register are dropped before storage.
    assign w0_commit = w0_ena && !(ZERO_REG && (w0_addr == '0));
    assign w1_commit = w1_ena && !(ZERO_REG && (w1_addr == '0));

    // Port 1 is assigned after port 0, so on a same-address collision the
    // port 1 value is the one that lands in storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w0_commit) begin
                regs[w0_addr] <= w0_data;
            end
            if (w1_commit) begin
                regs[w1_addr] <= w1_data;
            end
        end
    end

    // Busy bits are cleared by whichever ports write the register.
    regfile_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_ena   (sb_set_ena),
        .set_addr  (sb_set_addr),
        .clr0_ena  (w0_ena),
        .clr0_addr (w0_addr),
        .clr1_ena  (w1_ena),
        .clr1_addr (w1_addr),
        .flush     (sb_flush),
        .busy      (busy_vec)
    );

    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;

    // Each read port picks stored data, optionally overridden by same-cycle
    // write data with port 1 taking precedence. Address 0 is forced to zero
    // last so bypass can never leak into it. Outputs are held at zero while
    // reset is asserted, since bypass would otherwise expose in-flight data.
    always_comb begin
        r_data  = '0;
        r_busy  = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int k = 0; k < NRP; k++) begin
            rd_addr = r_addr[rd_addr_lo(k, AW) +: AW];
            rd_val  = regs[rd_addr];
            if (BYPASS) begin
                if (w1_ena && (w1_addr == rd_addr)) begin
                    rd_val = w1_data;
                end else if (w0_ena && (w0_addr == rd_addr)) begin
                    rd_val = w0_data;
                end
            end
            if (ZERO_REG && (rd_addr == '0)) begin
                rd_val = '0;
            end
            if (rst) begin
                r_data[rd_data_lo(k, XLEN) +: XLEN] = rd_val;
                r_busy[k] = busy_vec[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Instance A uses the default configuration
// (64-bit, 32 registers, 2 read ports, zero register, bypass); instance B uses
// 32-bit, 16 registers, 4 read ports, no zero register, no bypass.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals
    logic         a_w0_ena;
    logic [4:0]   a_w0_addr;
    logic [63:0]  a_w0_data;
    logic         a_w1_ena;
    logic [4:0]   a_w1_addr;
    logic [63:0]  a_w1_data;
    logic [9:0]   a_r_addr;
    logic [127:0] a_r_data;
    logic [1:0]   a_r_busy;
    logic         a_sb_set_ena;
    logic [4:0]   a_sb_set_addr;
    logic         a_sb_flush;
    logic [31:0]  a_busy_vec;

    // Instance B signals
    logic         b_w0_ena;
    logic [3:0]   b_w0_addr;
    logic [31:0]  b_w0_data;
    logic         b_w1_ena;
    logic [3:0]   b_w1_addr;
    logic [31:0]  b_w1_data;
    logic [15:0]  b_r_addr;
    logic [127:0] b_r_data;
    logic [3:0]   b_r_busy;
    logic         b_sb_set_ena;
    logic [3:0]   b_sb_set_addr;
    logic         b_sb_flush;
    logic [15:0]  b_busy_vec;

    regfile_mp #(
        .XLEN     (64),
        .NREG     (32),
        .NRP      (2),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b1)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .w0_ena      (a_w0_ena),
        .w0_addr     (a_w0_addr),
        .w0_data     (a_w0_data),
        .w1_ena      (a_w1_ena),
        .w1_addr     (a_w1_addr),
        .w1_data     (a_w1_data),
        .r_addr      (a_r_addr),
        .r_data      (a_r_data),
        .r_busy      (a_r_busy),
        .sb_set_ena  (a_sb_set_ena),
        .sb_set_addr (a_sb_set_addr),
        .sb_flush    (a_sb_flush),
        .busy_vec    (a_busy_vec)
    );

    regfile_mp #(
        .XLEN     (32),
        .NREG     (16),
        .NRP      (4),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .w0_ena      (b_w0_ena),
        .w0_addr     (b_w0_addr),
        .w0_data     (b_w0_data),
        .w1_ena      (b_w1_ena),
        .w1_addr     (b_w1_addr),
        .w1_data     (b_w1_data),
        .r_addr      (b_r_addr),
        .r_data      (b_r_data),
        .r_busy      (b_r_busy),
        .sb_set_ena  (b_sb_set_ena),
        .sb_set_addr (b_sb_set_addr),
        .sb_flush    (b_sb_flush),
        .busy_vec    (b_busy_vec)
    );

    task automatic idle_a();
        a_w0_ena = 1'b0; a_w0_addr = '0; a_w0_data = '0;
        a_w1_ena = 1'b0; a_w1_addr = '0; a_w1_data = '0;
        a_r_addr = '0;
        a_sb_set_ena = 1'b0; a_sb_set_addr = '0; a_sb_flush = 1'b0;
    endtask

    task automatic idle_b();
        b_w0_ena = 1'b0; b_w0_addr = '0; b_w0_data = '0;
        b_w1_ena = 1'b0; b_w1_addr = '0; b_w1_data = '0;
        b_r_addr = '0;
        b_sb_set_ena = 1'b0; b_sb_set_addr = '0; b_sb_flush = 1'b0;
    endtask

    task automatic test_reset();
        // Reset held from time zero, with a write presented to check bypass gating
        @(negedge clk);
        a_w0_ena = 1'b1; a_w0_addr = 5'd3; a_w0_data = 64'h1111;
        a_r_addr = {5'd3, 5'd3};
        #1;
        checks++;
        if (a_r_data !== '0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", a_r_data);
        end
        checks++;
        if (a_busy_vec !== '0) begin
            errors++; $display("[TB] FAIL reset_busy: got %h expected 0", a_busy_vec);
        end
        @(negedge clk);
        idle_a();
        rst = 1'b1;
        @(negedge clk);
        a_w0_ena = 1'b1; a_w0_addr = 5'd10; a_w0_data = 64'h1234;
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd12;
        @(negedge clk);
        idle_a();
        a_r_addr = {5'd3, 5'd10};
        #1;
        checks++;
        if (a_r_data[63:0] !== 64'h1234) begin
            errors++; $display("[TB] FAIL post_reset_write: got %h expected %h", a_r_data[63:0], 64'h1234);
        end
        checks++;
        if (a_r_data[127:64] !== 64'h0) begin
            errors++; $display("[TB] FAIL write_during_reset: got %h expected 0", a_r_data[127:64]);
        end
        checks++;
        if (a_busy_vec !== 32'h0000_1000) begin
            errors++; $display("[TB] FAIL post_reset_busy: got %h expected %h", a_busy_vec, 32'h0000_1000);
        end
        // Mid-run reset with a write in flight
        @(negedge clk);
        a_w0_ena = 1'b1; a_w0_addr = 5'd10; a_w0_data = 64'hAAAA;
        rst = 1'b0;
        #1;
        checks++;
        if (a_busy_vec !== '0) begin
            errors++; $display("[TB] FAIL midrst_busy: got %h expected 0", a_busy_vec);
        end
        for (int i = 0; i < 32; i++) begin
            a_r_addr = {i[4:0], i[4:0]};
            #1;
            checks++;
            if (a_r_data !== '0 || a_r_busy !== 2'b00) begin
                errors++; $display("[TB] FAIL midrst_read addr %0d: got %h/%b expected 0/00", i, a_r_data, a_r_busy);
            end
        end
        @(negedge clk);
        idle_a();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            a_r_addr = {i[4:0], i[4:0]};
            #1;
            checks++;
            if (a_r_data !== '0) begin
                errors++; $display("[TB] FAIL after_rst_read addr %0d: got %h expected 0", i, a_r_data);
            end
        end
        checks++;
        if (a_busy_vec !== '0) begin
            errors++; $display("[TB] FAIL after_rst_busy: got %h expected 0", a_busy_vec);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd5; a_w0_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        idle_a();
        a_r_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (a_r_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("[TB] FAIL write_read5: got %h expected %h", a_r_data[63:0], 64'hDEAD_BEEF_0000_0001);
        end
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd0; a_w0_data = 64'hFF;
        a_r_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (a_r_data[127:64] !== 64'h0) begin
            errors++; $display("[TB] FAIL zero_bypass: got %h expected 0", a_r_data[127:64]);
        end
        @(negedge clk);
        idle_a();
        a_r_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (a_r_data[63:0] !== 64'h0) begin
            errors++; $display("[TB] FAIL zero_reg_store: got %h expected 0", a_r_data[63:0]);
        end
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd9; a_w0_data = 64'h99;
        a_r_addr = {5'd9, 5'd5};
        #1;
        checks++;
        if (a_r_data[127:64] !== 64'h99) begin
            errors++; $display("[TB] FAIL bypass_w0: got %h expected %h", a_r_data[127:64], 64'h99);
        end
        checks++;
        if (a_r_data[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("[TB] FAIL bypass_other_port: got %h expected %h", a_r_data[63:0], 64'hDEAD_BEEF_0000_0001);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        idle_a(); idle_b();
        a_w0_ena = 1'b1; a_w0_addr = 5'd7; a_w0_data = 64'h33;
        b_w0_ena = 1'b1; b_w0_addr = 4'd7; b_w0_data = 32'h33;
        @(negedge clk);
        idle_a(); idle_b();
        a_w0_ena = 1'b1; a_w0_addr = 5'd7; a_w0_data = 64'h11;
        a_w1_ena = 1'b1; a_w1_addr = 5'd7; a_w1_data = 64'h22;
        b_w0_ena = 1'b1; b_w0_addr = 4'd7; b_w0_data = 32'h11;
        b_w1_ena = 1'b1; b_w1_addr = 4'd7; b_w1_data = 32'h22;
        a_r_addr = {5'd0, 5'd7};
        b_r_addr = {4'd0, 4'd0, 4'd0, 4'd7};
        #1;
        checks++;
        if (a_r_data[63:0] !== 64'h22) begin
            errors++; $display("[TB] FAIL collide_bypass: got %h expected %h", a_r_data[63:0], 64'h22);
        end
        checks++;
        if (b_r_data[31:0] !== 32'h33) begin
            errors++; $display("[TB] FAIL collide_nobypass: got %h expected %h", b_r_data[31:0], 32'h33);
        end
        @(negedge clk);
        idle_a(); idle_b();
        a_r_addr = {5'd0, 5'd7};
        b_r_addr = {4'd0, 4'd0, 4'd0, 4'd7};
        #1;
        checks++;
        if (a_r_data[63:0] !== 64'h22) begin
            errors++; $display("[TB] FAIL collide_store_a: got %h expected %h", a_r_data[63:0], 64'h22);
        end
        checks++;
        if (b_r_data[31:0] !== 32'h22) begin
            errors++; $display("[TB] FAIL collide_store_b: got %h expected %h", b_r_data[31:0], 32'h22);
        end
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd11; a_w0_data = 64'hB0;
        a_w1_ena = 1'b1; a_w1_addr = 5'd12; a_w1_data = 64'hC0;
        a_r_addr = {5'd12, 5'd11};
        #1;
        checks++;
        if (a_r_data !== {64'hC0, 64'hB0}) begin
            errors++; $display("[TB] FAIL dual_bypass: got %h expected %h", a_r_data, {64'hC0, 64'hB0});
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle_a();
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd3;
        a_r_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (a_r_busy[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL sb_set_early: got %b expected 0", a_r_busy[0]);
        end
        @(negedge clk);
        idle_a();
        a_r_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (a_busy_vec !== 32'h8) begin
            errors++; $display("[TB] FAIL sb_set_vec: got %h expected %h", a_busy_vec, 32'h8);
        end
        checks++;
        if (a_r_busy !== 2'b01) begin
            errors++; $display("[TB] FAIL sb_set_rbusy: got %b expected 01", a_r_busy);
        end
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd3; a_w0_data = 64'h5;
        a_r_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (a_r_busy[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL sb_clear_early: got %b expected 1", a_r_busy[0]);
        end
        @(negedge clk);
        idle_a();
        #1;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++; $display("[TB] FAIL sb_clear: got %h expected 0", a_busy_vec);
        end
        @(negedge clk);
        idle_a();
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd3;
        a_w1_ena = 1'b1; a_w1_addr = 5'd3; a_w1_data = 64'h6;
        @(negedge clk);
        idle_a();
        #1;
        checks++;
        if (a_busy_vec !== 32'h8) begin
            errors++; $display("[TB] FAIL sb_set_wins: got %h expected %h", a_busy_vec, 32'h8);
        end
        @(negedge clk);
        idle_a();
        a_w0_ena = 1'b1; a_w0_addr = 5'd3; a_w0_data = 64'h7;
        a_w1_ena = 1'b1; a_w1_addr = 5'd3; a_w1_data = 64'h8;
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd0;
        @(negedge clk);
        idle_a();
        #1;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++; $display("[TB] FAIL sb_dual_clear_zero: got %h expected 0", a_busy_vec);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        idle_a();
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd1;
        @(negedge clk);
        a_sb_set_addr = 5'd2;
        @(negedge clk);
        a_sb_set_addr = 5'd9;
        @(negedge clk);
        idle_a();
        #1;
        checks++;
        if (a_busy_vec !== 32'h0000_0206) begin
            errors++; $display("[TB] FAIL flush_pre: got %h expected %h", a_busy_vec, 32'h0000_0206);
        end
        @(negedge clk);
        idle_a();
        a_sb_flush = 1'b1;
        a_sb_set_ena = 1'b1; a_sb_set_addr = 5'd4;
        @(negedge clk);
        idle_a();
        #1;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++; $display("[TB] FAIL flush: got %h expected 0", a_busy_vec);
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        idle_b();
        b_w0_ena = 1'b1; b_w0_addr = 4'd0;  b_w0_data = 32'hA0A0_0001;
        b_w1_ena = 1'b1; b_w1_addr = 4'd15; b_w1_data = 32'hF0F0_000F;
        @(negedge clk);
        idle_b();
        b_w0_ena = 1'b1; b_w0_addr = 4'd4; b_w0_data = 32'h4444_4444;
        b_w1_ena = 1'b1; b_w1_addr = 4'd8; b_w1_data = 32'h8888_8888;
        b_sb_set_ena = 1'b1; b_sb_set_addr = 4'd0;
        @(negedge clk);
        idle_b();
        b_r_addr = {4'd7, 4'd15, 4'd4, 4'd0};
        #1;
        checks++;
        if (b_r_data !== {32'h22, 32'hF0F0_000F, 32'h4444_4444, 32'hA0A0_0001}) begin
            errors++; $display("[TB] FAIL sweep_read1: got %h expected %h", b_r_data,
                               {32'h22, 32'hF0F0_000F, 32'h4444_4444, 32'hA0A0_0001});
        end
        checks++;
        if (b_busy_vec !== 16'h0001) begin
            errors++; $display("[TB] FAIL sweep_busy0: got %h expected %h", b_busy_vec, 16'h0001);
        end
        checks++;
        if (b_r_busy !== 4'b0001) begin
            errors++; $display("[TB] FAIL sweep_rbusy: got %b expected 0001", b_r_busy);
        end
        @(negedge clk);
        idle_b();
        b_w0_ena = 1'b1; b_w0_addr = 4'd4; b_w0_data = 32'h5555_5555;
        b_r_addr = {4'd4, 4'd0, 4'd15, 4'd8};
        #1;
        checks++;
        if (b_r_data !== {32'h4444_4444, 32'hA0A0_0001, 32'hF0F0_000F, 32'h8888_8888}) begin
            errors++; $display("[TB] FAIL sweep_read2: got %h expected %h", b_r_data,
                               {32'h4444_4444, 32'hA0A0_0001, 32'hF0F0_000F, 32'h8888_8888});
        end
        @(negedge clk);
        idle_b();
        b_r_addr = {4'd4, 4'd0, 4'd15, 4'd8};
        #1;
        checks++;
        if (b_r_data[127:96] !== 32'h5555_5555) begin
            errors++; $display("[TB] FAIL sweep_update: got %h expected %h", b_r_data[127:96], 32'h5555_5555);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle_a();
        idle_b();
        $display("[TB] starting regfile_mp bench");
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_flush();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next CPU core generation.
- Configurable data width, register count and read-port count; two write ports (ALU and load/MUL writeback).
- Optional same-cycle write-to-read bypass; per-register busy scoreboard for issue-stage hazard checks.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 64, register data width in bits.
- NREG, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREG), register address width; derived, do not override.
- NRP, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored value only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- w0_ena  in  1  write port 0 enable.
- w0_addr  in  AW  write port 0 address.
- w0_data  in  XLEN  write port 0 data.
- w1_ena  in  1  write port 1 enable (priority port).
- w1_addr  in  AW  write port 1 address.
- w1_data  in  XLEN  write port 1 data.
- r_addr  in  NRP*AW  read addresses, port k at [k*AW +: AW].
- r_data  out  NRP*XLEN  read data, port k at [k*XLEN +: XLEN].
- r_busy  out  NRP  scoreboard busy bit of each read address.
- sb_set_ena  in  1  mark destination register pending (instruction issued).
- sb_set_addr  in  AW  register to mark pending.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  NREG  full scoreboard state, for debug and stall logic.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0. While rst=0: r_data=0, r_busy=0, busy_vec=0.
- Writes: commit on the rising clk edge when ena=1.
  - w0 and w1 enabled with the same address: w1 data is stored, w0 is dropped.
  - ZERO_REG=1: writes to address 0 are ignored, and reads of address 0 return 0.
- Reads: combinational, zero latency.
  - BYPASS=0: r_data shows the stored value only.
  - BYPASS=1: if w1_ena and w1_addr==r_addr, r_data = w1_data; else if w0_ena and w0_addr==r_addr, r_data = w0_data; else the stored value.
  - BYPASS=1 never forwards to address 0 when ZERO_REG=1.
- Scoreboard, updated on the rising clk edge:
  - sb_set_ena sets busy[sb_set_addr].
  - Any write enable clears busy[w*_addr].
  - Set and clear on the same register in the same cycle: set wins (a new producer was issued).
  - sb_flush=1 clears every bit and overrides set and clear in that cycle.
  - ZERO_REG=1: busy[0] is held at 0.
- r_busy[k] = busy[r_addr_k] from registered state, no bypass. A same-cycle clear therefore shows on r_busy one cycle later.
- Both write ports clearing the same bit: no conflict.
- No handshakes or back-pressure: every enable is accepted every cycle.
- Reset asserted mid-write: the write is lost and the state is all zero.

Decomposition:
- Package regfile_pkg holds:
  - Default XLEN and NREG constants.
  - Address-width helper function.
  - Localparams for the flattened-bus slice offsets.
- One sub-module, regfile_scoreboard: busy bit-vector with set/clear/flush priority logic.
- regfile_mp keeps storage, write arbitration and the bypass muxes.

Test Plan:
- Reset then read: assert rst=0 mid-run, read all addresses -> r_data=0 and busy_vec=0 while reset is low and after release.
- Write then read: write w0 addr 5 = 0xDEAD_BEEF_0000_0001, read addr 5 next cycle -> 0xDEAD_BEEF_0000_0001; write addr 0 = 0xFF -> reads 0 (ZERO_REG=1).
- Dual-write collision: w0 and w1 both to addr 7, data 0x11 and 0x22 -> stored 0x22. With BYPASS=1 the same-cycle read of addr 7 -> 0x22; with BYPASS=0 the same-cycle read returns the old value.
- Scoreboard set/clear: sb_set addr 3 -> busy_vec[3]=1 and r_busy=1 next cycle; w0 write addr 3 -> busy clears next cycle; sb_set addr 3 plus w1 write addr 3 in the same cycle -> busy stays 1.
- Flush: set addrs 1, 2, 9 and pulse sb_flush together with sb_set addr 4 -> busy_vec=0 next cycle.
- Parameter sweep: NREG=16, NRP=4, XLEN=32, ZERO_REG=0 -> addr 0 stores a value and all four read ports return independent correct data.
